// File: rtl/ntt_perm_tag_gen.sv
// Destination-tag generator for the NTT lane permutation network: walks stages x groups.
// Optional duplicate/out-of-range tag checker built when PERM_TAG_CHECK_EN is defined.

module ntt_perm_tag_lane #(
    parameter int LOGL = 2,
    parameter int SELW = 2,
    parameter int RW   = 1,
    parameter int LANE = 0
) (
    input  logic [RW-1:0]   i_rot,
    input  logic [LOGL-1:0] i_grp,
    output logic [SELW-1:0] o_tag
);
    localparam logic [LOGL-1:0] IDX = LOGL'(LANE);

    logic [2*LOGL-1:0] w_dbl;
    logic [LOGL-1:0]   w_sum;
    logic              w_unused;

    // Upper half of the doubled index after the shift is the LOGL-bit rotate-left.
    assign w_dbl    = {IDX, IDX} << i_rot;
    assign w_sum    = w_dbl[2*LOGL-1:LOGL] + i_grp;
    assign o_tag    = SELW'(w_sum);
    assign w_unused = ^w_dbl[LOGL-1:0];
endmodule

module ntt_perm_tag_gen #(
    parameter int N      = 8,
    parameter int SELW   = 3,
    parameter int LOGPTS = 8,
    parameter int NSTAGE = LOGPTS,
    parameter int ADDRW  = LOGPTS - $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [N*SELW-1:0]     dest_bus,
    output logic [ADDRW-1:0]      rd_addr,
    output logic [((NSTAGE>1)?$clog2(NSTAGE):1)-1:0] stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  perm_err
);
    localparam int LOGL = $clog2(N);
    localparam int SW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int RW   = (LOGL > 1) ? $clog2(LOGL) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [ADDRW-1:0]           r_grp, w_grp_nxt;
    logic [SW-1:0]              r_stg, w_stg_nxt;
    logic [N-1:0][SELW-1:0]     r_dest, w_dest_nxt;
    logic                       w_load, w_fire, w_last_grp, w_last_stg;
    logic [RW-1:0]              w_rot;

    assign w_fire     = (r_state == S_RUN) && out_ready;
    assign w_last_grp = &r_grp;
    assign w_last_stg = (r_stg == SW'(NSTAGE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort outranks start and fire; start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        w_stg_nxt   = r_stg;
        w_load      = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_grp_nxt   = '0;
            w_stg_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    w_state_nxt = S_RUN;
                    w_grp_nxt   = '0;
                    w_stg_nxt   = '0;
                    w_load      = 1'b1;
                end
                S_RUN: if (w_fire) begin
                    if (w_last_grp) begin
                        w_grp_nxt = '0;
                        if (w_last_stg) begin
                            w_stg_nxt   = '0;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_stg_nxt = r_stg + 1'b1;
                            w_load    = 1'b1;
                        end
                    end else begin
                        w_grp_nxt = r_grp + 1'b1;
                        w_load    = 1'b1;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_rot = RW'(w_stg_nxt % LOGL);

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        ntt_perm_tag_lane #(.LOGL(LOGL), .SELW(SELW), .RW(RW), .LANE(gi)) u_lane (
            .i_rot (w_rot),
            .i_grp (LOGL'(w_grp_nxt)),
            .o_tag (w_dest_nxt[gi])
        );
    end

    // Tags are only reloaded alongside a new valid vector, so they hold through stalls and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grp  <= '0;
            r_stg  <= '0;
            r_dest <= '0;
        end else begin
            r_grp <= w_grp_nxt;
            r_stg <= w_stg_nxt;
            if (w_load) r_dest <= w_dest_nxt;
        end
    end

    assign out_valid = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign dest_bus  = r_dest;
    assign rd_addr   = r_grp;
    assign stage_idx = r_stg;

`ifdef PERM_TAG_CHECK_EN
    logic w_bad, r_err;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'(r_dest[i]) >= N) w_bad = 1'b1;
            for (int j = i + 1; j < N; j++)
                if (r_dest[i] == r_dest[j]) w_bad = 1'b1;
        end
    end

    // Sticky until reset; start/abort deliberately leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= r_err | (out_valid & w_bad);
    end

    assign perm_err = r_err;
`else
    assign perm_err = 1'b0;
`endif
endmodule
